// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RV32M multiply/divide unit that sits in EX beside the ALU. It
// holds the front of the pipeline through stall_o while it works, then
// presents a registered result to the EX->MEM register with done_o.
// Multiply takes a fixed two cycles. Divide and remainder use a restoring
// radix-2 loop of XLEN iterations, so they finish at cycle XLEN+1. Divide
// by zero and signed overflow finish at cycle 1.
//
// Build option:
//   MULDIV_DIV_EN  When defined, the divider datapath and the DIV state are
//                  built. When undefined, funct3[2]=1 takes the two-cycle
//                  multiply path and returns 0.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   reset      synchronous, active-high reset
//   start_i    valid M-extension instruction in EX (level, held while stalled)
//   funct3_i   M-extension operation select
//   src_a_i    rs1 operand (already forwarded)
//   src_b_i    rs2 operand (already forwarded)
//   advance_i  EX->MEM register enabled this cycle
//   flush_i    instruction in EX is killed
//   stall_o    hold IF/ID/EX (combinational)
//   done_o     result_o is valid for the instruction in EX
//   result_o   registered 32-bit result
// ---------------------------------------------------------------------------
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] src_a_i,
   input  logic [XLEN-1:0] src_b_i,
   input  logic            advance_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

`ifdef MULDIV_DIV_EN
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif

   state_t            state;
   logic [2:0]        funct3_q;
   logic [XLEN-1:0]   op_a;
   logic [XLEN-1:0]   op_b;
   logic              a_signed;
   logic              b_signed;
   logic [2*XLEN-1:0] a_ext;
   logic [2*XLEN-1:0] b_ext;
   logic [2*XLEN-1:0] product;
   logic [XLEN-1:0]   mul_result;

   // Multiply datapath. Both operands are widened to 2*XLEN and then
   // multiplied. Keeping only the low 2*XLEN bits of the product gives the
   // correct result for every signed/unsigned mix, because the arithmetic
   // is modulo 2^(2*XLEN). A divide opcode never reaches MUL in the
   // divider build. Without the divider, a divide opcode reaches MUL and
   // must return 0.
   always_comb begin
      a_signed   = (funct3_q[1:0] == 2'b01) || (funct3_q[1:0] == 2'b10);
      b_signed   = (funct3_q[1:0] == 2'b01);
      a_ext      = {{XLEN{a_signed & op_a[XLEN-1]}}, op_a};
      b_ext      = {{XLEN{b_signed & op_b[XLEN-1]}}, op_b};
      product    = a_ext * b_ext;
      mul_result = (funct3_q[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
      if (funct3_q[2]) begin
         mul_result = '0;
      end
   end

`ifdef MULDIV_DIV_EN
   localparam int            CW         = $clog2(XLEN + 1);
   localparam logic [CW-1:0] COUNT_INIT = CW'(XLEN);
   localparam logic [CW-1:0] COUNT_LAST = CW'(1);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [CW-1:0]   count;
   logic [XLEN-1:0] rem_q;
   logic            neg_q;
   logic            neg_r;
   logic            in_signed;
   logic            in_neg_a;
   logic            in_neg_b;
   logic            in_b_zero;
   logic            in_ovf;
   logic [XLEN-1:0] in_mag_a;
   logic [XLEN-1:0] in_mag_b;
   logic [XLEN-1:0] special_result;
   logic [XLEN:0]   rem_shift;
   logic [XLEN:0]   diff;
   logic            rem_ge;
   logic [XLEN-1:0] rem_next;
   logic [XLEN-1:0] quo_next;
   logic [XLEN-1:0] div_result;

   // Divide setup from the live operands while in IDLE. Signed ops divide
   // the magnitudes and apply the signs at the end. Divide by zero and
   // signed overflow are detected here so the loop can be skipped.
   always_comb begin
      in_signed = ~funct3_i[0];
      in_neg_a  = in_signed & src_a_i[XLEN-1];
      in_neg_b  = in_signed & src_b_i[XLEN-1];
      in_mag_a  = in_neg_a ? -src_a_i : src_a_i;
      in_mag_b  = in_neg_b ? -src_b_i : src_b_i;
      in_b_zero = (src_b_i == '0);
      in_ovf    = in_signed & (src_a_i == MOST_NEG) & (src_b_i == '1);
      if (in_b_zero) begin
         special_result = funct3_i[1] ? src_a_i : '1;
      end else begin
         special_result = funct3_i[1] ? '0 : MOST_NEG;
      end
   end

   // One restoring step per cycle. op_a doubles as the dividend shift
   // register: each cycle its MSB moves into the partial remainder and the
   // new quotient bit enters at its LSB. After XLEN steps op_a holds the
   // quotient. The partial remainder is widened by one bit so that the
   // borrow of the trial subtraction decides whether to restore.
   always_comb begin
      rem_shift  = {rem_q, op_a[XLEN-1]};
      diff       = rem_shift - {1'b0, op_b};
      rem_ge     = ~diff[XLEN];
      rem_next   = rem_ge ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
      quo_next   = {op_a[XLEN-2:0], rem_ge};
      div_result = funct3_q[1] ? (neg_r ? -rem_next : rem_next)
                               : (neg_q ? -quo_next : quo_next);
   end
`endif

   // The stall is removed once the result is ready. It is also removed when
   // the instruction is flushed, because nothing needs to wait for it.
   assign stall_o = start_i & ~done_o & ~flush_i & ~reset;

   // Control FSM with registered done_o/result_o. Reset wins over flush,
   // and flush wins over every other transition. A flush never touches
   // result_o.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         funct3_q <= '0;
         op_a     <= '0;
         op_b     <= '0;
         result_o <= '0;
         done_o   <= 1'b0;
`ifdef MULDIV_DIV_EN
         count    <= '0;
         rem_q    <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
`endif
      end else if (flush_i) begin
         state  <= IDLE;
         done_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  funct3_q <= funct3_i;
`ifdef MULDIV_DIV_EN
                  if (funct3_i[2]) begin
                     op_a  <= in_mag_a;
                     op_b  <= in_mag_b;
                     neg_q <= in_neg_a ^ in_neg_b;
                     neg_r <= in_neg_a;
                     rem_q <= '0;
                     count <= COUNT_INIT;
                     if (in_b_zero || in_ovf) begin
                        result_o <= special_result;
                        done_o   <= 1'b1;
                        state    <= DONE;
                     end else begin
                        state <= DIV;
                     end
                  end else begin
                     op_a  <= src_a_i;
                     op_b  <= src_b_i;
                     state <= MUL;
                  end
`else
                  op_a  <= src_a_i;
                  op_b  <= src_b_i;
                  state <= MUL;
`endif
               end
            end
            MUL: begin
               result_o <= mul_result;
               done_o   <= 1'b1;
               state    <= DONE;
            end
`ifdef MULDIV_DIV_EN
            DIV: begin
               op_a  <= quo_next;
               rem_q <= rem_next;
               count <= count - COUNT_LAST;
               if (count == COUNT_LAST) begin
                  result_o <= div_result;
                  done_o   <= 1'b1;
                  state    <= DONE;
               end
            end
`endif
            DONE: begin
               if (advance_i) begin
                  done_o <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               state  <= IDLE;
               done_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Iterative RV32M multiply/divide unit in the EX stage, beside the ALU.
- Takes operands and funct3 for an M-extension instruction in EX and holds the pipeline via `stall_o` while it works.
- Presents a 32-bit result to the EX→MEM pipeline register as `multiplier_resultE` on the `done_o` cycle.
- Multiply takes a fixed 2 cycles; divide/remainder uses a restoring radix-2 loop of XLEN iterations.

## Interface
- XLEN, 32, operand/result width and divide iteration count; only 32 is supported in the core.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  reset, synchronous, active-high.
- start_i  input  1  valid M-extension instruction present in EX (level, held while stalled).
- funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src_a_i  input  XLEN  rs1 operand, already forwarded.
- src_b_i  input  XLEN  rs2 operand, already forwarded.
- advance_i  input  1  EX→MEM register enabled this cycle (no other stall source).
- flush_i  input  1  instruction in EX is killed.
- stall_o  output  1  hold IF/ID/EX stages; combinational.
- done_o  output  1  `result_o` valid for the instruction in EX.
- result_o  output  XLEN  registered result.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Reset: state IDLE, result_o=0, done_o=0, stall_o=0, all internal registers 0.
- IDLE:
  - start_i=1 and flush_i=0: latch funct3, operands and operand signs.
  - funct3[2]=0 → MUL.
  - funct3[2]=1 with b=0 or signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM) → DONE with special result.
  - Otherwise → DIV with counter=XLEN.
- MUL:
  - Form the 64-bit product; operands are sign- or zero-extended per funct3 (MULHSU: a signed, b unsigned).
  - MUL returns product[31:0]; the others return product[63:32].
  - Register the result → DONE.
- DIV:
  - Operate on magnitudes for DIV/REM and raw values for DIVU/REMU.
  - Each cycle: shift remainder left by 1 and bring in the next dividend MSB. If remainder ≥ divisor, subtract and set the quotient bit.
  - Decrement counter; at counter=1, apply signs and register the result → DONE.
  - Quotient is negated if sign_a^sign_b; remainder takes the sign of a.
- DONE:
  - done_o=1.
  - advance_i=1 → IDLE.
  - advance_i=0 → stay in DONE, holding result_o and done_o.
- Special results:
  - Div by zero: quotient 0xFFFFFFFF, remainder = a.
  - Overflow: quotient 0x80000000, remainder 0.
- stall_o = start_i & ~done_o & ~flush_i & ~reset.
- flush_i=1 in any state: go to IDLE next cycle, done_o=0; result_o is not updated.
- reset has priority over flush_i, which has priority over all other transitions.

## Timing
- start_i sampled in IDLE at cycle 0.
- Multiply: MUL at cycle 1, DONE at cycle 2. Stall for 2 cycles.
- Divide: DIV for cycles 1..XLEN, DONE at cycle XLEN+1. Stall for 33 cycles.
- Special-case divide: DONE at cycle 1. Stall for 1 cycle.
- Back-to-back: if advance_i=1 in DONE, the next instruction's start_i is sampled in the following IDLE cycle. There is no dead cycle beyond that IDLE sample.
- In DONE, start_i does not restart the unit.
- Reset mid-operation: IDLE next edge, partial results discarded.

## Configuration
- MULDIV_DIV_EN defined: full divider datapath, DIV state and special cases as above.
- MULDIV_DIV_EN undefined:
  - No divider logic and no DIV state.
  - funct3[2]=1 takes the MUL path (2-cycle latency) and returns 0.

## Test plan
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD):
  - stall_o high for 2 cycles.
  - done_o at cycle 2 with result 0xFFFFFFEB.
  - With advance_i=1, IDLE next cycle.
- MULH / MULHSU / MULHU with a=0x80000000, b=0xFFFFFFFF:
  - Results 0x00000000, 0x80000000, 0x7FFFFFFF respectively.
- DIV -7/2 and REM -7/2:
  - done_o at cycle 33.
  - Results 0xFFFFFFFD and 0xFFFFFFFF.
  - DIVU 100/7 = 14, REMU = 2.
- DIVU 5/0 and DIV 0x80000000/0xFFFFFFFF:
  - done_o at cycle 1.
  - Results 0xFFFFFFFF and 0x80000000.
  - REM for the same operands gives 5 and 0.
- DIV started, flush_i at cycle 10:
  - IDLE at cycle 11, done_o never asserted.
  - A new MUL started at cycle 11 completes correctly at cycle 13.
- DONE with advance_i=0 for 3 cycles:
  - result_o and done_o held, stall_o low.
  - reset asserted during a DIV at cycle 5: all outputs 0 the next cycle.
